// File: rtl/seq_multiplier_param_if.sv
// Start/done handshake and operand/result bus of the sequential multiplier.
// The requester drives operands and start; the multiplier returns product, busy and done.
interface seq_multiplier_param_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     data1;
  logic [WIDTH-1:0]     data2;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;

  modport master (
    output start, signed_mode, data1, data2,
    input  product, busy, done
  );

  modport slave (
    input  start, signed_mode, data1, data2,
    output product, busy, done
  );
endinterface

// File: rtl/seq_multiplier_param.sv
// Radix-2 shift-add multiplier, WIDTH cycles per product, signed or unsigned per operation.
// Operands are converted to magnitudes on accept; the sign is reapplied when the result is stored.
module seq_multiplier_param #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  seq_multiplier_param_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    ONE_C = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P = PW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [WIDTH-1:0]  mag1_reg, mag1_next;
  logic [WIDTH-1:0]  mag2_reg, mag2_next;
  logic              neg_reg, neg_next;
  logic [PW-1:0]     acc_reg, acc_next;
  logic [PW-1:0]     product_reg, product_next;

  logic              busy;
  logic              done;
  logic              accept;
  logic [PW-1:0]     acc_sum;
  logic [PW-1:0]     addend;

  logic [WIDTH-1:0]  opnd   [2];
  logic [WIDTH-1:0]  mag_in [2];
  logic              sgn_in [2];

  assign opnd[0] = bus.data1;
  assign opnd[1] = bus.data2;

  // |x| of the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
  for (genvar gi = 0; gi < 2; gi++) begin : g_mag
    assign sgn_in[gi] = bus.signed_mode & opnd[gi][WIDTH-1];
    assign mag_in[gi] = sgn_in[gi] ? (~opnd[gi] + ONE_W) : opnd[gi];
  end

  assign addend  = mag2_reg[0] ? ({{WIDTH{1'b0}}, mag1_reg} << cnt_reg) : '0;
  assign acc_sum = acc_reg + addend;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    mag1_next    = mag1_reg;
    mag2_next    = mag2_reg;
    neg_next     = neg_reg;
    acc_next     = acc_reg;
    product_next = product_reg;
    busy         = 1'b0;
    done         = 1'b0;
    accept       = 1'b0;

    case (state_reg)
      IDLE: begin
        accept = bus.start;
      end
      RUN: begin
        busy      = 1'b1;
        acc_next  = acc_sum;
        mag2_next = mag2_reg >> 1;
        cnt_next  = cnt_reg + ONE_C;
        // The final partial product is folded in on the same edge that stores the result
        if (cnt_reg == LAST) begin
          state_next   = DONE;
          cnt_next     = '0;
          product_next = neg_reg ? (~acc_sum + ONE_P) : acc_sum;
        end
      end
      DONE: begin
        done   = 1'b1;
        accept = bus.start;
        if (!bus.start) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (accept) begin
      state_next = RUN;
      mag1_next  = mag_in[0];
      mag2_next  = mag_in[1];
      neg_next   = sgn_in[0] ^ sgn_in[1];
      acc_next   = '0;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      cnt_reg     <= '0;
      mag1_reg    <= '0;
      mag2_reg    <= '0;
      neg_reg     <= 1'b0;
      acc_reg     <= '0;
      product_reg <= '0;
    end else begin
      cnt_reg     <= cnt_next;
      mag1_reg    <= mag1_next;
      mag2_reg    <= mag2_next;
      neg_reg     <= neg_next;
      acc_reg     <= acc_next;
      product_reg <= product_next;
    end
  end

  assign bus.product = product_reg;
  assign bus.busy    = busy;
  assign bus.done    = done;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Scoreboard bench: drivers queue the expected product and done cycle, per-width monitors pop on done.
module tb_seq_multiplier_param;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  seq_multiplier_param_if #(.WIDTH(8))  b8 ();
  seq_multiplier_param_if #(.WIDTH(4))  b4 ();
  seq_multiplier_param_if #(.WIDTH(16)) b16 ();

  seq_multiplier_param #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(b8));
  seq_multiplier_param #(.WIDTH(4))  dut4  (.clk(clk), .reset_n(reset_n), .bus(b4));
  seq_multiplier_param #(.WIDTH(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(b16));

  typedef struct {
    logic [63:0] prod;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t sb8[$];
  exp_t sb4[$];
  exp_t sb16[$];
  exp_t e8, e4, e16, ei;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  function automatic logic [63:0] refm(int w, bit s, logic [31:0] a, logic [31:0] b);
    longint x, y, p, m;
    m = (longint'(1) << w) - 1;
    x = longint'(a) & m;
    y = longint'(b) & m;
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return 64'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Monitors
  always @(negedge clk) begin
    if (b8.done) begin
      if (sb8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL w8 unexpected_done: done at cycle %0d, required none", cyc);
      end else begin
        e8 = sb8.pop_front();
        check({e8.tag, " product"}, 64'(b8.product), e8.prod);
        check({e8.tag, " done_cycle"}, 64'(cyc), 64'(e8.cyc));
      end
    end
    n_checks++;
    if (b8.busy && b8.done) begin
      n_fail++;
      $display("FAIL w8 busy_and_done: both high at cycle %0d, required exclusive", cyc);
    end
  end

  always @(negedge clk) begin
    if (b4.done) begin
      if (sb4.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL w4 unexpected_done: done at cycle %0d, required none", cyc);
      end else begin
        e4 = sb4.pop_front();
        check({e4.tag, " product"}, 64'(b4.product), e4.prod);
        check({e4.tag, " done_cycle"}, 64'(cyc), 64'(e4.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (b16.done) begin
      if (sb16.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL w16 unexpected_done: done at cycle %0d, required none", cyc);
      end else begin
        e16 = sb16.pop_front();
        check({e16.tag, " product"}, 64'(b16.product), e16.prod);
        check({e16.tag, " done_cycle"}, 64'(cyc), 64'(e16.cyc));
      end
    end
  end

  // Issue one WIDTH=8 operation; scrambles inputs afterwards to prove they were latched
  task automatic go8(string tag, bit s, logic [7:0] a, logic [7:0] b, logic [15:0] p, bit expect_done);
    exp_t e;
    @(posedge clk); #1;
    b8.start = 1'b1; b8.signed_mode = s; b8.data1 = a; b8.data2 = b;
    if (expect_done) begin
      e.prod = 64'(p); e.cyc = cyc + 1 + 8; e.tag = tag;
      sb8.push_back(e);
    end
    @(posedge clk); #1;
    b8.start = 1'b0; b8.signed_mode = ~s;
    b8.data1 = 8'($urandom); b8.data2 = 8'($urandom);
  endtask

  task automatic wait_idle8(string tag);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb8.size() == 0 && !b8.busy && !b8.done) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: %0d results outstanding, required 0", tag, sb8.size());
      sb8.delete();
    end
  endtask

  logic [31:0] ra, rb;
  bit          rs;
  int          nbusy;
  logic [7:0]  hv_a [3];
  logic [7:0]  hv_b [3];
  bit          hv_s [3];
  logic [15:0] hv_p [3];

  initial begin
    reset_n = 1'b1;
    b8.start = 0;  b8.signed_mode = 0;  b8.data1 = 0;  b8.data2 = 0;
    b4.start = 0;  b4.signed_mode = 0;  b4.data1 = 0;  b4.data2 = 0;
    b16.start = 0; b16.signed_mode = 0; b16.data1 = 0; b16.data2 = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("reset product", 64'(b8.product), 64'h0);
    check("reset busy", 64'(b8.busy), 64'h0);
    check("reset done", 64'(b8.done), 64'h0);

    // Basic unsigned with busy-duration check
    go8("u 1A*2D", 0, 8'h1A, 8'h2D, 16'h0492, 1);
    nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b8.busy) nbusy++;
    end
    check("busy cycles", 64'(nbusy), 64'd8);
    wait_idle8("basic");

    go8("u FF*FF", 0, 8'hFF, 8'hFF, 16'hFE01, 1); wait_idle8("max");
    go8("u 64*B3", 0, 8'h64, 8'hB3, 16'h45EC, 1); wait_idle8("mixed");
    go8("s C7*31", 1, 8'hC7, 8'h31, 16'hF517, 1); wait_idle8("signed");
    go8("u C7*31", 0, 8'hC7, 8'h31, 16'h2617, 1); wait_idle8("unsigned_same");
    go8("s 80*80", 1, 8'h80, 8'h80, 16'h4000, 1); wait_idle8("min_min");
    go8("s FF*FF", 1, 8'hFF, 8'hFF, 16'h0001, 1); wait_idle8("neg_one");
    go8("u 00*5A", 0, 8'h00, 8'h5A, 16'h0000, 1); wait_idle8("zero");

    // start pulsed mid-RUN must be ignored
    go8("midrun 12*34", 0, 8'h12, 8'h34, 16'h03A8, 1);
    repeat (2) @(posedge clk); #1;
    b8.start = 1'b1; b8.data1 = 8'hFF; b8.data2 = 8'hFF;
    @(posedge clk); #1;
    b8.start = 1'b0;
    wait_idle8("midrun");

    // start held high: back-to-back ops, done every 9 cycles, fresh operands per accept
    hv_a[0] = 8'hC7; hv_b[0] = 8'h31; hv_s[0] = 1; hv_p[0] = 16'hF517;
    hv_a[1] = 8'h64; hv_b[1] = 8'hB3; hv_s[1] = 0; hv_p[1] = 16'h45EC;
    hv_a[2] = 8'h80; hv_b[2] = 8'h01; hv_s[2] = 1; hv_p[2] = 16'hFF80;
    @(posedge clk); #1;
    b8.start = 1'b1; b8.signed_mode = hv_s[0]; b8.data1 = hv_a[0]; b8.data2 = hv_b[0];
    ei.prod = 64'(hv_p[0]); ei.cyc = cyc + 9; ei.tag = "held #0"; sb8.push_back(ei);
    @(posedge clk); #1;
    for (int k = 1; k < 3; k++) begin
      b8.signed_mode = hv_s[k]; b8.data1 = hv_a[k]; b8.data2 = hv_b[k];
      ei.prod = 64'(hv_p[k]); ei.cyc = cyc + 17; ei.tag = $sformatf("held #%0d", k);
      sb8.push_back(ei);
      repeat (9) @(posedge clk); #1;
    end
    b8.start = 1'b0;
    wait_idle8("held");

    // Reset on the 4th RUN edge, with a coincident start that must be ignored
    go8("rst AB*CD", 0, 8'hAB, 8'hCD, 16'h0, 0);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1; b8.start = 1'b1; b8.data1 = 8'h11; b8.data2 = 8'h22;
    @(posedge clk); #1;
    reset_n = 1'b0; b8.start = 1'b0;
    @(negedge clk);
    check("midreset product", 64'(b8.product), 64'h0);
    check("midreset busy", 64'(b8.busy), 64'h0);
    check("midreset done", 64'(b8.done), 64'h0);
    repeat (12) @(negedge clk);
    check("post-reset busy", 64'(b8.busy), 64'h0);
    go8("u 07*06", 0, 8'h07, 8'h06, 16'h002A, 1); wait_idle8("after_reset");

    // Width sweeps against a signed/unsigned reference
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      b4.start = 1'b1; b4.signed_mode = rs; b4.data1 = ra[3:0]; b4.data2 = rb[3:0];
      ei.prod = refm(4, rs, ra, rb); ei.cyc = cyc + 1 + 4; ei.tag = $sformatf("w4 #%0d", i);
      sb4.push_back(ei);
      @(posedge clk); #1;
      b4.start = 1'b0;
      repeat (4) @(posedge clk);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      b16.start = 1'b1; b16.signed_mode = rs; b16.data1 = ra[15:0]; b16.data2 = rb[15:0];
      ei.prod = refm(16, rs, ra, rb); ei.cyc = cyc + 1 + 16; ei.tag = $sformatf("w16 #%0d", i);
      sb16.push_back(ei);
      @(posedge clk); #1;
      b16.start = 1'b0;
      repeat (16) @(posedge clk);
    end
    repeat (20) @(negedge clk);
    if (sb4.size() != 0 || sb16.size() != 0 || sb8.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d/%0d/%0d results outstanding, required 0", sb8.size(), sb4.size(), sb16.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_param.md
# seq_multiplier_param

Parametrised sequential shift-add multiplier, the successor of the fixed 8-bit multiplier. It supports any operand width, runtime signed/unsigned mode, a busy flag, and back-to-back operation. It sits on the datapath as a low-area multi-cycle arithmetic unit driven by a start/done handshake.

## Interface
- WIDTH, 8, operand width in bits (≥ 2); product is 2*WIDTH bits.
- clk  input  1  rising-edge clock, sole clock domain.
- reset_n  input  1  synchronous, active-high reset; the name is kept from the existing block but the polarity is high (1 = reset).
- start  input  1  request to begin a multiply; sampled on the clock edge.
- signed_mode  input  1  1 = two's-complement operands/product, 0 = unsigned; sampled with start.
- data1  input  WIDTH  multiplicand; sampled with start.
- data2  input  WIDTH  multiplier; sampled with start.
- product  output  2*WIDTH  result; holds last completed value until the next done.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when product is updated.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, iteration counter 0..WIDTH-1.
  - DONE: done=1, busy=0.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --counter==WIDTH-1--> DONE.
  - DONE --start--> RUN, allowing back-to-back operations.
  - DONE --!start--> IDLE.
- Start acceptance:
  - start is accepted only in IDLE or DONE.
  - start during RUN is ignored; operands in flight are unaffected.
- Load on accept:
  - Signed mode: register mag1=|data1| and mag2=|data2| as WIDTH-bit unsigned, and neg = data1[MSB] ^ data2[MSB].
  - Unsigned mode: mag = raw operand, neg = 0.
  - Clear the 2*WIDTH accumulator and the counter.
  - All inputs are latched; later changes to data1, data2 or signed_mode do not affect the operation.
- RUN iteration, radix-2, one per cycle:
  - If mag2[0], accumulator += mag1 shifted left by the counter value. Equivalently, a shift-register form may be used; only the result matters.
  - Then shift mag2 right and increment the counter.
- Finalise (RUN → DONE edge):
  - product = neg ? (~acc + 1) : acc, taken modulo 2^(2*WIDTH).
  - The product register updates on this edge only.
- Width rules:
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits WIDTH unsigned bits.
  - Signed min×min = 2^(2*WIDTH-2), which is representable; no overflow case exists.
- Zero operands: the full WIDTH-cycle latency still applies (no early termination) and the product is 0.
- Reset (reset_n=1 at an edge), including mid-RUN:
  - state=IDLE, product=0, done=0, busy=0, counter=0, accumulator=0.
  - Any in-flight operation is discarded with no done pulse.
  - A start coincident with reset is ignored.

## Timing
- Reset values: product=0, busy=0, done=0.
- Start accepted at edge E0:
  - busy=1 from after E0 through WIDTH cycles.
  - At edge E0+WIDTH, product updates and done=1 for exactly one cycle (E0+WIDTH to E0+WIDTH+1).
- Latency start-edge → done-edge = WIDTH cycles. With WIDTH=8 at a 100 ns period, that is 800 ns.
- Back-to-back: if start=1 during the DONE cycle, the next op is accepted at E0+WIDTH+1 and the next done follows WIDTH cycles later. Throughput is one result per WIDTH+1 cycles.
- busy and done are never high simultaneously.
- Holding start high continuously yields repeated operations, each using the operands present at its accept edge.

## Test plan
- Unsigned basic, WIDTH=8: reset, then start with data1=0x1A, data2=0x2D, signed_mode=0 -> done 8 cycles after accept, product=0x0492 (1170); busy high for 8 cycles.
- Unsigned max and mixed: data1=0xFF, data2=0xFF -> product=0xFE01; data1=0x64, data2=0xB3 -> product=0x45EC (17900).
- Signed mode: data1=0xC7 (-57), data2=0x31 (49) -> product=0xF517 (-2793). The same operands with signed_mode=0 -> product=0x2617 (9751). Signed 0x80×0x80 -> product=0x4000.
- Handshake robustness:
  - start pulsed again mid-RUN with different operands -> ignored; the first result is correct and there is exactly one done.
  - start held high -> back-to-back results with done spaced 9 cycles apart.
- Reset mid-operation: assert reset_n=1 at cycle 4 of RUN -> next cycle product=0, busy=0, and no done pulse. A new start afterwards (0x07×0x06) -> product=0x002A.
- Parameter sweep: WIDTH=4 and WIDTH=16 against a random signed/unsigned reference model (≥1000 vectors each) -> exact match, with latency equal to WIDTH cycles.
